// File: rtl/uart_rx_top.sv
// uart_rx_top: 16x oversampled UART receive engine.
// Detects the start bit, samples the start, data, parity and stop bits at
// mid-bit (data LSB first, 5..8 bits, optional odd/even/sticky parity, one
// stop bit) and emits a one-clock push strobe carrying the assembled byte
// together with parity, framing and break status.
// All receive activity advances only on clk edges where baud_pulse=1.
// push is a pure strobe with no back-pressure: the consumer must accept the
// byte in the clock that push is high; rx_out/pe/fe/bi then hold until the
// next push.
module uart_rx_top (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       sticky_parity,
    input  logic       eps,
    input  logic       pen,
    input  logic [1:0] wls,
    output logic       push,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic [7:0] rx_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_bit_q, par_bit_d;
    logic        par_err_q, par_err_d;
    logic        push_q, push_d;
    logic        pe_q, pe_d;
    logic        fe_q, fe_d;
    logic        bi_q, bi_d;
    logic [7:0]  rx_out_q, rx_out_d;

    logic        last_bit;
    logic        exp_par;

    // Index of the final data bit is word length minus one (wls + 4).
    assign last_bit = (bitcnt_q == ({1'b0, wls} + 3'd4));

    // Unused upper shift bits are cleared at frame start, so a full-width
    // reduction gives the parity of just the received data bits.
    assign exp_par = sticky_parity ? ~eps : (eps ? ^shift_q : ~^shift_q);

    // Next-state and next-output computation; nothing moves without a tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        push_d    = 1'b0;
        pe_d      = pe_q;
        fe_d      = fe_q;
        bi_d      = bi_q;
        rx_out_d  = rx_out_q;
        if (baud_pulse) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx) begin
                        state_d = S_START;
                        cnt_d   = 4'd0;
                    end
                end
                S_START: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (!rx) begin
                            state_d   = S_DATA;
                            cnt_d     = 4'd0;
                            bitcnt_d  = 3'd0;
                            shift_d   = 8'd0;
                            par_bit_d = 1'b0;
                            par_err_d = 1'b0;
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        cnt_d             = 4'd0;
                        shift_d[bitcnt_q] = rx;
                        if (last_bit) begin
                            state_d = pen ? S_PARITY : S_STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        cnt_d     = 4'd0;
                        par_bit_d = rx;
                        par_err_d = rx ^ exp_par;
                        state_d   = S_STOP;
                    end
                end
                S_STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        cnt_d    = 4'd0;
                        push_d   = 1'b1;
                        rx_out_d = shift_q;
                        fe_d     = ~rx;
                        pe_d     = pen & par_err_q;
                        bi_d     = (shift_q == 8'd0) & (~par_bit_q | ~pen) & ~rx;
                        state_d  = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State and registered outputs; synchronous reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            bitcnt_q  <= 3'd0;
            shift_q   <= 8'd0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            push_q    <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
            rx_out_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            par_err_q <= par_err_d;
            push_q    <= push_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
            rx_out_q  <= rx_out_d;
        end
    end

    assign push   = push_q;
    assign pe     = pe_q;
    assign fe     = fe_q;
    assign bi     = bi_q;
    assign rx_out = rx_out_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Bench for uart_rx_top: a table of hand-computed frames, hand-written
// multi-cycle sequences (glitch, mid-frame reset) and random frames checked
// against a frame-level reference model.
module tb_uart_rx_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b0;
    logic       rx = 1'b1;
    logic       sticky_parity = 1'b0;
    logic       eps = 1'b0;
    logic       pen = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       push;
    logic       pe;
    logic       fe;
    logic       bi;
    logic [7:0] rx_out;

    int checks = 0;
    int errors = 0;
    int push_cnt = 0;
    int div = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       sticky;
        logic       par_bit;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_bi;
    } vec_t;

    vec_t vecs[10];

    uart_rx_top dut (
        .clk          (clk),
        .rst          (rst),
        .baud_pulse   (baud_pulse),
        .rx           (rx),
        .sticky_parity(sticky_parity),
        .eps          (eps),
        .pen          (pen),
        .wls          (wls),
        .push         (push),
        .pe           (pe),
        .fe           (fe),
        .bi           (bi),
        .rx_out       (rx_out)
    );

    // clock / baud generation
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div == 5) begin
            div = 0;
            baud_pulse = 1'b1;
        end else begin
            div = div + 1;
            baud_pulse = 1'b0;
        end
    end

    // count clocks with push high, sampled away from the active edge
    always @(negedge clk) begin
        if (push === 1'b1) push_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_wait();
        do @(posedge clk); while (baud_pulse !== 1'b1);
        #1;
    endtask

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (16) tick_wait();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        int n;
        n = int'(wls) + 5;
        hold_bit(1'b0);
        for (int i = 0; i < n; i++) hold_bit(d[i]);
        if (pen) hold_bit(par_bit);
        hold_bit(stop_bit);
        rx = 1'b1;
        repeat (6) tick_wait();
    endtask

    // Frame-level reference: what the receiver reports for one frame.
    function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] w,
                                          input logic p, input logic e, input logic s,
                                          input logic pb, input logic st);
        int n;
        int ones;
        logic [7:0] m;
        logic exp_par, r_pe, r_fe, r_bi;
        n = int'(w) + 5;
        m = 8'd0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            m[i] = d[i];
            if (d[i]) ones++;
        end
        if (s) exp_par = ~e;
        else if (e) exp_par = (ones % 2 == 1);
        else exp_par = (ones % 2 == 0);
        r_pe = p && (pb != exp_par);
        r_fe = !st;
        r_bi = (m == 8'd0) && (!p || !pb) && !st;
        return {m, r_pe, r_fe, r_bi};
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int base;
        wls = v.wls;
        pen = v.pen;
        eps = v.eps;
        sticky_parity = v.sticky;
        base = push_cnt;
        send_frame(v.data, v.par_bit, v.stop);
        check($sformatf("%s push_count", tag), push_cnt - base, 1);
        check($sformatf("%s rx_out", tag), rx_out, v.exp_data);
        check($sformatf("%s pe", tag), pe, v.exp_pe);
        check($sformatf("%s fe", tag), fe, v.exp_fe);
        check($sformatf("%s bi", tag), bi, v.exp_bi);
    endtask

    initial begin
        vec_t v;
        logic [10:0] r;
        int base;

        // data, wls, pen, eps, sticky, par_bit, stop, exp_data, exp_pe, exp_fe, exp_bi
        vecs[0] = '{8'h45, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h45, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h45, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h45, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h45, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h45, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{8'h15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h45, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h45, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h45, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h45, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h3A, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3A, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'h7F, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};

        // reset block
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset push", push, 1'b0);
        check("reset rx_out", rx_out, 8'h00);
        check("reset pe", pe, 1'b0);
        check("reset fe", fe, 1'b0);
        check("reset bi", bi, 1'b0);

        // table-driven frames
        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // glitch: rx low for 4 ticks only must not produce a frame
        base = push_cnt;
        rx = 1'b0;
        repeat (4) tick_wait();
        rx = 1'b1;
        repeat (20) tick_wait();
        check("glitch push_count", push_cnt - base, 0);
        check("glitch rx_out held", rx_out, 8'h7F);
        v = '{8'hA6, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA6, 1'b0, 1'b0, 1'b0};
        run_vec(v, "after_glitch");

        // reset in the middle of the data bits
        wls = 2'b11; pen = 1'b1; eps = 1'b0; sticky_parity = 1'b0;
        base = push_cnt;
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        repeat (20) tick_wait();
        check("midreset push_count", push_cnt - base, 0);
        check("midreset rx_out", rx_out, 8'h00);
        check("midreset pe", pe, 1'b0);
        check("midreset fe", fe, 1'b0);
        check("midreset bi", bi, 1'b0);
        run_vec(vecs[0], "after_reset");

        // random frames against the reference model
        for (int k = 0; k < 16; k++) begin
            v.data    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) v.data = 8'h00;
            v.wls     = 2'($urandom_range(0, 3));
            v.pen     = 1'($urandom_range(0, 1));
            v.eps     = 1'($urandom_range(0, 1));
            v.sticky  = 1'($urandom_range(0, 1));
            v.par_bit = 1'($urandom_range(0, 1));
            v.stop    = ($urandom_range(0, 4) != 0);
            r = model(v.data, v.wls, v.pen, v.eps, v.sticky, v.par_bit, v.stop);
            v.exp_data = r[10:3];
            v.exp_pe   = r[2];
            v.exp_fe   = r[1];
            v.exp_bi   = r[0];
            run_vec(v, $sformatf("rand%0d", k));
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
